count_step_monitor: RTL
=======================

# count_step_monitor

Downstream checker for the 3-bit up/down counter: samples the counter's `count` and `mode` every clock and verifies each step is exactly +1 (mode 0) or −1 (mode 1) modulo 8. It reports wrap-around events and step errors, and raises a sticky fault after repeated consecutive errors. It sits beside the counter in the sequential lab top level and feeds status LEDs or the bench scoreboard.

## Interface
- `WRAP_W`, 8: width of the wrap event counter.
- `ERR_W`, 8: width of the error event counter.
- `ERR_LIMIT`, 3: consecutive step errors that force FAULT; legal range 1..7.
- `LOCK_N`, 4: consecutive good steps needed to assert `locked`; legal range 1..15.

Ports:
- `clk` input 1: rising-edge clock shared with the counter.
- `reset` input 1: synchronous, active-high; same net as the counter reset.
- `mode` input 1: counter direction; 0 = up, 1 = down.
- `count` input 3: counter output.
- `wrap_pulse` output 1: one-cycle pulse on a legal 7→0 (up) or 0→7 (down) step.
- `wrap_count` output WRAP_W: saturating count of wrap events.
- `step_error` output 1: one-cycle pulse on an illegal step.
- `error_count` output ERR_W: saturating count of step errors.
- `locked` output 1: high once LOCK_N consecutive good steps are seen in TRACK.
- `fault` output 1: sticky until reset; high in FAULT.

## Operation
- Registers:
  - `prev_count[2:0]` and `prev_mode`.
  - `good_run` (4 bits, saturates at LOCK_N).
  - `err_run` (3 bits).
  - `state ∈ {INIT, TRACK, FAULT}`.
- The expected value is `prev_count+1` mod 8 when `prev_mode`=0, else `prev_count−1` mod 8.
  - The counter applies `mode` on the edge after it changes, so the check uses the previous mode, not the current one.
- INIT: capture `count`/`mode` into prev. Go to TRACK. No checks and no pulses.
- TRACK, good step (`count == expected`):
  - `err_run←0`; `good_run` increments.
  - When `good_run` reaches LOCK_N, `locked←1`.
  - A wrap step also sets `wrap_pulse` and increments `wrap_count`.
- TRACK, bad step:
  - Set `step_error` and increment `error_count`.
  - `good_run←0`, `locked←0`, `err_run` increments.
  - When `err_run` reaches ERR_LIMIT, go to FAULT.
- FAULT:
  - `fault=1` and `locked=0`.
  - `error_count` still counts bad steps.
  - `wrap_pulse` is suppressed and `wrap_count` is frozen.
  - Leaves FAULT only on reset.
- prev registers always load the actual sampled `count`/`mode`. This re-syncs after a glitch, so a single corrupted value costs at most 2 errors.
- Hold (`count == prev_count`) is a bad step.
- Counters saturate at all-ones and never wrap.
- A wrap step with a mode change in the same cycle: judged by `prev_mode` only; the new mode affects the next check.

## Timing
- All outputs are registered.
- A step sampled at posedge t appears on `wrap_pulse`/`step_error` after posedge t. Pulses last exactly one cycle.
- Reset (sampled high at a posedge):
  - `state←INIT`, all outputs 0, prev registers 0, `good_run` and `err_run` 0.
  - Reset overrides every other condition, including mid-FAULT and mid-pulse.
- First check is at the second posedge after `reset` falls (INIT consumes one sample).
- `locked` rises after LOCK_N+1 posedges following INIT.

## Structure
- Shared package (`counter_pkg`):
  - state typedef `{INIT, TRACK, FAULT}`.
  - `MODE_UP=1'b0` and `MODE_DOWN=1'b1`.
  - `CNT_W=3`, also used by the counter.
- One natural sub-module, `sat_counter #(W)`: enable-driven saturating increment with synchronous reset. Instantiated for `wrap_count` and `error_count`.
- Step prediction is a combinational function inside the monitor.

## Test plan
- **Up-count wrap:** reset 2 cycles, then mode=0 and the counter counts 0..7,0..7. Required: no `step_error`; `wrap_pulse` on each 7→0 step; `wrap_count`=2 after 16 steps; `locked`=1 after the 5th posedge.
- **Mode change:** mode flips 0→1 while `count`=5, and the counter produces 6,5,4. Required: no error; `prev_mode` governs each check.
- **Down wrap:** mode=1 from 2. Sequence 2,1,0,7. Required: `wrap_pulse` once on 0→7; `wrap_count`=1.
- **Single glitch:** force `count`=3 for one cycle where 6 is expected, then release. Required:
  - 2 `step_error` pulses; `error_count`=2; `locked` drops.
  - No `fault`; `locked` returns after 4 good steps.
- **Stuck count:** hold `count`=4 for 3 cycles. Required: 3 errors, `fault`=1, `wrap_count` frozen across later 7→0 steps; reset clears everything to 0.
- **Saturation:** WRAP_W=2, run 5 wraps. Required: `wrap_count` stays at 3.

Source files
------------

// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg
// Definitions shared by the 3-bit up/down counter and its step monitor:
// counter width, direction encodings and the monitor state type.
// ---------------------------------------------------------------------------
package counter_pkg;

  // Width of the counter value.
  localparam int CNT_W = 3;

  // Direction encodings carried on the counter's mode input.
  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

  // Frequently used counter values.
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Monitor states.
  typedef enum logic [1:0] {
    INIT  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

endpackage : counter_pkg

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Enable-driven event counter that sticks at all-ones instead of wrapping.
// The count is registered, so it reflects the events sampled up to and
// including the most recent clock edge.
//
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high; clears the count
//   en    : count one event on this edge
//   q     : current count (W bits), saturating at all-ones
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] Q_MAX = '1;
  localparam logic [W-1:0] Q_ONE = W'(1);

  logic [W-1:0] r_q;
  logic [W-1:0] w_q_nxt;

  // Next count: increment on enable unless already saturated.
  always_comb begin
    w_q_nxt = r_q;
    if (en && (r_q != Q_MAX)) begin
      w_q_nxt = r_q + Q_ONE;
    end else begin
      w_q_nxt = r_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else begin
      r_q <= w_q_nxt;
    end
  end

  assign q = r_q;

endmodule : sat_counter

// File: rtl/count_step_monitor.sv
// ---------------------------------------------------------------------------
// count_step_monitor
// Watches a 3-bit up/down counter and checks that every sampled step is
// exactly +1 (mode up) or -1 (mode down) modulo 8. Reports legal wrap steps
// and illegal steps as one-cycle pulses with saturating event counters,
// asserts locked after a run of good steps, and enters a sticky fault after
// too many consecutive bad steps.
//
// Ports:
//   clk         : rising-edge clock shared with the counter
//   reset       : synchronous, active-high (same net as counter reset)
//   mode        : counter direction, 0 = up, 1 = down
//   count       : counter value (3 bits)
//   wrap_pulse  : one-cycle pulse on a legal 7->0 (up) or 0->7 (down) step
//   wrap_count  : saturating count of wrap events (WRAP_W bits)
//   step_error  : one-cycle pulse on an illegal step
//   error_count : saturating count of illegal steps (ERR_W bits)
//   locked      : LOCK_N consecutive good steps seen while tracking
//   fault       : sticky until reset; ERR_LIMIT consecutive bad steps seen
// ---------------------------------------------------------------------------
module count_step_monitor
  import counter_pkg::*;
#(
  parameter int WRAP_W    = 8,
  parameter int ERR_W     = 8,
  parameter int ERR_LIMIT = 3,  // legal range 1..7
  parameter int LOCK_N    = 4   // legal range 1..15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode,
  input  logic [CNT_W-1:0]  count,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              step_error,
  output logic [ERR_W-1:0]  error_count,
  output logic              locked,
  output logic              fault
);

  localparam logic [3:0] LOCK_N_C    = 4'(LOCK_N);
  localparam logic [2:0] ERR_LIMIT_C = 3'(ERR_LIMIT);

  // Value the counter must show next, given its previous value and the mode
  // it was running with when that value was sampled. The counter applies a
  // new mode one edge late, so the previous mode is the one that matters.
  function automatic logic [CNT_W-1:0] predict_step(
    input logic [CNT_W-1:0] prev_count,
    input logic             prev_mode
  );
    logic [CNT_W-1:0] nxt;
    if (prev_mode == MODE_DOWN) begin
      nxt = prev_count - CNT_ONE;
    end else begin
      nxt = prev_count + CNT_ONE;
    end
    return nxt;
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_prev_count;
  logic             r_prev_mode;
  logic [3:0]       r_good_run;
  logic [3:0]       w_good_run_nxt;
  logic [2:0]       r_err_run;
  logic [2:0]       w_err_run_nxt;
  logic [2:0]       w_err_run_inc;
  logic             r_wrap_pulse;
  logic             w_wrap_pulse_nxt;
  logic             r_step_error;
  logic             w_step_error_nxt;
  logic             r_locked;
  logic             w_locked_nxt;
  logic             r_fault;
  logic             w_fault_nxt;
  logic [CNT_W-1:0] w_expected;
  logic             w_good_step;
  logic             w_wrap_step;

  assign w_expected    = predict_step(r_prev_count, r_prev_mode);
  assign w_good_step   = (count == w_expected);
  // A wrap is a good step leaving the end of the range in the direction of
  // the previous mode; a simultaneous mode change does not matter.
  assign w_wrap_step   = w_good_step &&
                         (((r_prev_mode == MODE_UP)   && (r_prev_count == CNT_MAX)) ||
                          ((r_prev_mode == MODE_DOWN) && (r_prev_count == CNT_ZERO)));
  assign w_err_run_inc = r_err_run + 3'd1;

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt      = r_state;
    w_good_run_nxt   = r_good_run;
    w_err_run_nxt    = r_err_run;
    w_wrap_pulse_nxt = 1'b0;
    w_step_error_nxt = 1'b0;
    w_locked_nxt     = r_locked;
    w_fault_nxt      = r_fault;

    case (r_state)
      INIT: begin
        // Only seeds the previous-sample registers; nothing is judged yet.
        w_state_nxt    = TRACK;
        w_good_run_nxt = 4'd0;
        w_err_run_nxt  = 3'd0;
        w_locked_nxt   = 1'b0;
        w_fault_nxt    = 1'b0;
      end

      TRACK: begin
        if (w_good_step) begin
          w_err_run_nxt = 3'd0;
          if (r_good_run < LOCK_N_C) begin
            w_good_run_nxt = r_good_run + 4'd1;
          end else begin
            w_good_run_nxt = r_good_run;
          end
          w_locked_nxt     = (w_good_run_nxt >= LOCK_N_C);
          w_wrap_pulse_nxt = w_wrap_step;
        end else begin
          w_step_error_nxt = 1'b1;
          w_good_run_nxt   = 4'd0;
          w_locked_nxt     = 1'b0;
          w_err_run_nxt    = w_err_run_inc;
          if (w_err_run_inc >= ERR_LIMIT_C) begin
            w_state_nxt = FAULT;
            w_fault_nxt = 1'b1;
          end else begin
            w_state_nxt = TRACK;
          end
        end
      end

      FAULT: begin
        // Still reports bad steps, but wraps are ignored until reset.
        w_step_error_nxt = ~w_good_step;
        w_locked_nxt     = 1'b0;
        w_fault_nxt      = 1'b1;
      end

      default: begin
        // Unreachable encoding: treat as a fault rather than resume tracking.
        w_state_nxt  = FAULT;
        w_locked_nxt = 1'b0;
        w_fault_nxt  = 1'b1;
      end
    endcase
  end

  // State, run-length, previous-sample and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= INIT;
      r_prev_count <= CNT_ZERO;
      r_prev_mode  <= MODE_UP;
      r_good_run   <= 4'd0;
      r_err_run    <= 3'd0;
      r_wrap_pulse <= 1'b0;
      r_step_error <= 1'b0;
      r_locked     <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      // Always follow the actual sample so a single glitch re-syncs.
      r_prev_count <= count;
      r_prev_mode  <= mode;
      r_good_run   <= w_good_run_nxt;
      r_err_run    <= w_err_run_nxt;
      r_wrap_pulse <= w_wrap_pulse_nxt;
      r_step_error <= w_step_error_nxt;
      r_locked     <= w_locked_nxt;
      r_fault      <= w_fault_nxt;
    end
  end

  sat_counter #(.W(WRAP_W)) u_wrap_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (w_wrap_pulse_nxt),
    .q     (wrap_count)
  );

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (w_step_error_nxt),
    .q     (error_count)
  );

  assign wrap_pulse = r_wrap_pulse;
  assign step_error = r_step_error;
  assign locked     = r_locked;
  assign fault      = r_fault;

endmodule : count_step_monitor
